// File: rtl/sna_pkg.sv
// sna_pkg: shared definitions for the serial nibble adder.
//   sna_state_t : controller state encoding (IDLE, ADD, DONE)
//   NIB_W       : width of one adder slice (one nibble)
package sna_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } sna_state_t;

endpackage

// File: rtl/carry_ripple_adder.sv
// carry_ripple_adder: 4-bit combinational ripple-carry adder slice.
//   a_i, b_i : nibble operands
//   cin_i    : carry into bit 0
//   sum_o    : nibble sum
//   cout_o   : carry out of bit 3
module carry_ripple_adder
  import sna_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             cin_i,
  output logic [NIB_W-1:0] sum_o,
  output logic             cout_o
);

  logic [NIB_W:0] carry_s;

  // Full-adder chain, carry rippling from bit 0 upward.
  always_comb begin
    carry_s    = {(NIB_W+1){1'b0}};
    sum_o      = {NIB_W{1'b0}};
    carry_s[0] = cin_i;
    for (int i = 0; i < NIB_W; i++) begin
      sum_o[i]       = a_i[i] ^ b_i[i] ^ carry_s[i];
      carry_s[i + 1] = (a_i[i] & b_i[i]) | (carry_s[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry_s[NIB_W];
  end

endmodule

// File: rtl/serial_nibble_adder.sv
// serial_nibble_adder: WIDTH-bit adder that reuses one 4-bit carry_ripple_adder,
// processing one nibble per cycle (least significant first).
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (a, b, cin [, sub])
//   out_valid, out_ready: result handshake (sum, cout)
// Optional macro SNA_SUB_EN adds the 'sub' port: when latched high the block
// computes a - b (cout = 1 means no borrow) and ignores cin.
module serial_nibble_adder
  import sna_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SNA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  sna_state_t       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;
`ifdef SNA_SUB_EN
  logic             sub_q;
`endif

  logic [NIB_W-1:0] a_nib_s;
  logic [NIB_W-1:0] b_sel_s;
  logic [NIB_W-1:0] b_nib_s;
  logic [NIB_W-1:0] slice_sum_s;
  logic             slice_cout_s;

  // Select the current nibble of each operand and splice the slice result into the sum.
  always_comb begin
    a_nib_s = {NIB_W{1'b0}};
    b_sel_s = {NIB_W{1'b0}};
    sum_d   = sum_q;
    for (int n = 0; n < NIB; n++) begin
      a_nib_s = (idx_q == IDX_W'(n)) ? a_q[n*NIB_W +: NIB_W] : a_nib_s;
      b_sel_s = (idx_q == IDX_W'(n)) ? b_q[n*NIB_W +: NIB_W] : b_sel_s;
      sum_d[n*NIB_W +: NIB_W] = (idx_q == IDX_W'(n)) ? slice_sum_s : sum_q[n*NIB_W +: NIB_W];
    end
`ifdef SNA_SUB_EN
    // Subtraction is a + ~b + 1; the +1 comes from the carry seeded at accept.
    b_nib_s = sub_q ? ~b_sel_s : b_sel_s;
`else
    b_nib_s = b_sel_s;
`endif
  end

  carry_ripple_adder u_slice (
    .a_i    (a_nib_s),
    .b_i    (b_nib_s),
    .cin_i  (carry_q),
    .sum_o  (slice_sum_s),
    .cout_o (slice_cout_s)
  );

  // Controller, operand latches and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= {IDX_W{1'b0}};
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      sum_q       <= {WIDTH{1'b0}};
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SNA_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            idx_q      <= {IDX_W{1'b0}};
            in_ready_q <= 1'b0;
            state_q    <= ADD;
`ifdef SNA_SUB_EN
            sub_q      <= sub;
            carry_q    <= sub ? 1'b1 : cin;
`else
            carry_q    <= cin;
`endif
          end
        end
        ADD: begin
          sum_q   <= sum_d;
          carry_q <= slice_cout_s;
          if (idx_q == IDX_W'(NIB - 1)) begin
            cout_q      <= slice_cout_s;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean idle state.
          state_q     <= IDLE;
          idx_q       <= {IDX_W{1'b0}};
          carry_q     <= 1'b0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// tb_serial_nibble_adder: directed self-checking bench for serial_nibble_adder (WIDTH = 16).
module tb_serial_nibble_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
`ifdef SNA_SUB_EN
  logic        sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  serial_nibble_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SNA_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (armed) chk("excl", {31'd0, in_ready & out_valid}, 32'd0);
  endtask

  task automatic wait_out(input string tag);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, 32'd4);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_lo"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ir_hi"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_add(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic [15:0] es, input logic ec);
    a = av; b = bv; cin = ci; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_ir_busy"}, {31'd0, in_ready}, 32'd0);
    wait_out(tag);
    chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, "_ir_done"}, {31'd0, in_ready}, 32'd0);
    handshake(tag);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 16'd0; b = 16'd0; cin = 1'b0;
`ifdef SNA_SUB_EN
    sub = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    armed = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);

    // Basic adds and full carry ripple.
    do_add("add1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    do_add("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    do_add("cin_rip", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    do_add("mixed", 16'hA5C3, 16'h5A3C, 1'b1, 16'h0000, 1'b1);
    do_add("topcar", 16'h8000, 16'h8001, 1'b0, 16'h0001, 1'b1);
    do_add("plain", 16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0);

    // Backpressure: hold out_ready low for 3 cycles.
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out("bp");
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_ov", {31'd0, out_valid}, 32'd1);
      chk("bp_sum", {16'd0, sum}, 32'h1010);
      chk("bp_cout", {31'd0, cout}, 32'd0);
      chk("bp_ir", {31'd0, in_ready}, 32'd0);
    end
    handshake("bp");

    // Reset during the 2nd ADD cycle aborts the operation.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_ir", {31'd0, in_ready}, 32'd1);
    chk("mrst_ov", {31'd0, out_valid}, 32'd0);
    chk("mrst_sum", {16'd0, sum}, 32'd0);
    chk("mrst_cout", {31'd0, cout}, 32'd0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    chk("mrst_never_valid", seen, 32'd0);
    do_add("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);

    // Reset and in_valid together: nothing is accepted.
    rst = 1'b1; in_valid = 1'b1; a = 16'h00FF; b = 16'h00FF;
    step();
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("rst_vs_valid_ir", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    chk("rst_vs_valid_nores", seen, 32'd0);

    // Input churn during ADD/DONE must not disturb the latched operands.
    a = 16'h0102; b = 16'h0304; cin = 1'b0; in_valid = 1'b1;
    step();
    seen = 0;
    while (out_valid !== 1'b1 && seen < 20) begin
      in_valid = ~in_valid;
      a = 16'($urandom());
      b = 16'($urandom());
      cin = ~cin;
      step();
      seen++;
    end
    chk("churn_lat", seen, 32'd4);
    chk("churn_sum", {16'd0, sum}, 32'h0406);
    chk("churn_cout", {31'd0, cout}, 32'd0);
    a = 16'h1000; b = 16'h2000; cin = 1'b0; in_valid = 1'b1;
    step();
    chk("churn_done_ir", {31'd0, in_ready}, 32'd0);
    chk("churn_done_sum", {16'd0, sum}, 32'h0406);
    handshake("churn");
    step();
    in_valid = 1'b0;
    wait_out("second");
    chk("second_sum", {16'd0, sum}, 32'h3000);
    chk("second_cout", {31'd0, cout}, 32'd0);
    handshake("second");

`ifdef SNA_SUB_EN
    sub = 1'b1;
    do_add("sub_neg", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
    do_add("sub_pos", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
    do_add("sub_cin_ign", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1);
    sub = 1'b0;
    do_add("sub_off", 16'h0007, 16'h0005, 1'b1, 16'h000D, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
